// File: rtl/simple_system_bus.sv
// simple_system_bus
// Single-cycle request/response interconnect between NrHosts bus masters and
// NrDevices slaves. One host wins per cycle by fixed priority (lowest index),
// its address is decoded by base/mask to one device (lowest index on multiple
// hits), and the routing is registered so the response one cycle later is
// steered back to the host that was granted.
//
// Ports
//   clk_i                 system clock, all state on rising edge
//   rst_i                 synchronous reset, active-high
//   host_req_i/gnt_o      per-host request and same-cycle grant
//   host_addr/we/be/wdata request fields from each host
//   host_rvalid/rdata/err response returned to each host
//   device_req_o          per-device request, qualified by decode
//   device_addr/we/be/wdata  winning host's request fields, fanned out to all devices
//   device_rvalid/rdata/err  device responses, one cycle after their request
//   cfg_device_addr_base/mask  address map, one base/mask pair per device

module simple_system_bus #(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [NrHosts-1:0]      host_req_i,
    output logic [NrHosts-1:0]      host_gnt_o,
    input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]      host_we_i,
    input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]      host_rvalid_o,
    output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]      host_err_o,

    output logic [NrDevices-1:0]    device_req_o,
    output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
    output logic [NrDevices-1:0]    device_we_o,
    output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
    output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
    input  logic [NrDevices-1:0]    device_rvalid_i,
    input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
    input  logic [NrDevices-1:0]    device_err_i,

    input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

    localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic                host_found;
    logic [HostIdxW-1:0] host_sel_d;
    logic                dev_found;
    logic [DevIdxW-1:0]  dev_sel_d;

    logic                pending_q;
    logic                miss_q;
    logic [HostIdxW-1:0] host_sel_q;
    logic [DevIdxW-1:0]  dev_sel_q;

    // Fixed-priority arbitration: the first requesting host in index order wins.
    always_comb begin
        host_found = 1'b0;
        host_sel_d = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (!host_found && host_req_i[h]) begin
                host_found = 1'b1;
                host_sel_d = HostIdxW'(h);
            end
        end
    end

    // Decode the winning host's address; the first matching device wins.
    always_comb begin
        dev_found = 1'b0;
        dev_sel_d = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!dev_found &&
                ((host_addr_i[host_sel_d] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
                dev_found = 1'b1;
                dev_sel_d = DevIdxW'(d);
            end
        end
    end

    // A host is granted even on a decode miss so it never stalls on a bad address.
    always_comb begin
        host_gnt_o = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = host_found && (host_sel_d == HostIdxW'(h));
        end
    end

    // Request fields are broadcast to every device; only req selects the target.
    always_comb begin
        device_req_o = '0;
        device_we_o  = '0;
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = host_found && dev_found && (dev_sel_d == DevIdxW'(d));
            device_addr_o[d]  = host_addr_i[host_sel_d];
            device_we_o[d]    = host_we_i[host_sel_d];
            device_be_o[d]    = host_be_i[host_sel_d];
            device_wdata_o[d] = host_wdata_i[host_sel_d];
        end
    end

    // Routing is captured every cycle; pending only marks cycles that had a grant,
    // so a reset drops whatever response was about to be delivered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= 1'b0;
            miss_q     <= 1'b0;
            host_sel_q <= '0;
            dev_sel_q  <= '0;
        end else begin
            pending_q  <= host_found;
            miss_q     <= !dev_found;
            host_sel_q <= host_sel_d;
            dev_sel_q  <= dev_sel_d;
        end
    end

    // Steer the device response (or a synthesized error for a miss) back to the
    // host recorded at grant time; every other host sees all zeros.
    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = '0;
            if (pending_q && (host_sel_q == HostIdxW'(h))) begin
                if (miss_q) begin
                    host_rvalid_o[h] = 1'b1;
                    host_err_o[h]    = 1'b1;
                end else begin
                    host_rvalid_o[h] = device_rvalid_i[dev_sel_q];
                    host_err_o[h]    = device_err_i[dev_sel_q];
                    host_rdata_o[h]  = device_rdata_i[dev_sel_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_simple_system_bus.sv
// tb_simple_system_bus
// Directed bench for simple_system_bus with two hosts and three devices
// (RAM at 0x0010_0000/64K, sim control at 0x0002_0000/4K, timer at 0x0003_0000/4K).
// Device responses are driven by hand in the cycle after each request.

module tb_simple_system_bus;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  host_req_i;
    logic [1:0]  host_gnt_o;
    logic [31:0] host_addr_i  [2];
    logic [1:0]  host_we_i;
    logic [3:0]  host_be_i    [2];
    logic [31:0] host_wdata_i [2];
    logic [1:0]  host_rvalid_o;
    logic [31:0] host_rdata_o [2];
    logic [1:0]  host_err_o;
    logic [2:0]  device_req_o;
    logic [31:0] device_addr_o  [3];
    logic [2:0]  device_we_o;
    logic [3:0]  device_be_o    [3];
    logic [31:0] device_wdata_o [3];
    logic [2:0]  device_rvalid_i;
    logic [31:0] device_rdata_i [3];
    logic [2:0]  device_err_i;
    logic [31:0] cfg_device_addr_base [3];
    logic [31:0] cfg_device_addr_mask [3];

    int total = 0;
    int bad   = 0;

    simple_system_bus #(
        .NrDevices(3), .NrHosts(2), .DataWidth(32), .AddressWidth(32)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
        .host_addr_i(host_addr_i), .host_we_i(host_we_i),
        .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .host_err_o(host_err_o),
        .device_req_o(device_req_o), .device_addr_o(device_addr_o),
        .device_we_o(device_we_o), .device_be_o(device_be_o),
        .device_wdata_o(device_wdata_o),
        .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
        .device_err_i(device_err_i),
        .cfg_device_addr_base(cfg_device_addr_base),
        .cfg_device_addr_mask(cfg_device_addr_mask)
    );

    always #5 clk_i = ~clk_i;

    // Drive one host's request fields.
    task automatic applyStimulus(input int h, input logic req, input logic [31:0] addr,
                                 input logic we, input logic [3:0] be, input logic [31:0] wdata);
        host_req_i[h]   = req;
        host_addr_i[h]  = addr;
        host_we_i[h]    = we;
        host_be_i[h]    = be;
        host_wdata_i[h] = wdata;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one device's response fields.
    task automatic deviceResp(input int d, input logic rv, input logic [31:0] rdata, input logic err);
        device_rvalid_i[d] = rv;
        device_rdata_i[d]  = rdata;
        device_err_i[d]    = err;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clearDevices();
        for (int d = 0; d < 3; d++) deviceResp(d, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        cfg_device_addr_base[0] = 32'h0010_0000; cfg_device_addr_mask[0] = 32'hFFFF_0000;
        cfg_device_addr_base[1] = 32'h0002_0000; cfg_device_addr_mask[1] = 32'hFFFF_F000;
        cfg_device_addr_base[2] = 32'h0003_0000; cfg_device_addr_mask[2] = 32'hFFFF_F000;
        applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        clearDevices();
        rst_i = 1'b1;
        nextCycle();
        nextCycle();
        rst_i = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("rst_rvalid", 32'(host_rvalid_o), 32'h0);
        checkOutput("rst_err", 32'(host_err_o), 32'h0);
        checkOutput("rst_gnt", 32'(host_gnt_o), 32'h0);
        checkOutput("rst_dreq", 32'(device_req_o), 32'h0);

        $display("[TB] RAM read");
        applyStimulus(0, 1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("t1_gnt", 32'(host_gnt_o), 32'h1);
        checkOutput("t1_dreq", 32'(device_req_o), 32'h1);
        checkOutput("t1_daddr", device_addr_o[0], 32'h0010_0010);
        nextCycle();
        host_req_i[0] = 1'b0;
        deviceResp(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        #1;
        checkOutput("t1_rvalid", 32'(host_rvalid_o), 32'h1);
        checkOutput("t1_rdata", host_rdata_o[0], 32'hDEAD_BEEF);
        checkOutput("t1_err", 32'(host_err_o), 32'h0);
        checkOutput("t1_rdata_h1", host_rdata_o[1], 32'h0);
        nextCycle();
        clearDevices();
        #1;
        checkOutput("t1_idle_rvalid", 32'(host_rvalid_o), 32'h0);

        $display("[TB] sim control write");
        applyStimulus(0, 1'b1, 32'h0002_0000, 1'b1, 4'h1, 32'h0000_0041);
        #1;
        checkOutput("t2_gnt", 32'(host_gnt_o), 32'h1);
        checkOutput("t2_dreq", 32'(device_req_o), 32'h2);
        checkOutput("t2_daddr", device_addr_o[1], 32'h0002_0000);
        checkOutput("t2_dwdata", device_wdata_o[1], 32'h0000_0041);
        checkOutput("t2_dbe", 32'(device_be_o[1]), 32'h1);
        checkOutput("t2_dwe", 32'(device_we_o[1]), 32'h1);
        nextCycle();
        host_req_i[0] = 1'b0;
        deviceResp(1, 1'b1, 32'h0, 1'b0);
        #1;
        checkOutput("t2_rvalid", 32'(host_rvalid_o), 32'h1);
        nextCycle();
        clearDevices();

        $display("[TB] timer error");
        applyStimulus(0, 1'b1, 32'h0003_0004, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("t3_dreq", 32'(device_req_o), 32'h4);
        nextCycle();
        host_req_i[0] = 1'b0;
        deviceResp(2, 1'b1, 32'h1234_5678, 1'b1);
        #1;
        checkOutput("t3_rvalid", 32'(host_rvalid_o), 32'h1);
        checkOutput("t3_err", 32'(host_err_o), 32'h1);
        nextCycle();
        clearDevices();

        $display("[TB] unmapped access");
        applyStimulus(1, 1'b1, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("t4_gnt", 32'(host_gnt_o), 32'h2);
        checkOutput("t4_dreq", 32'(device_req_o), 32'h0);
        nextCycle();
        host_req_i[1] = 1'b0;
        #1;
        checkOutput("t4_rvalid", 32'(host_rvalid_o), 32'h2);
        checkOutput("t4_err", 32'(host_err_o), 32'h2);
        checkOutput("t4_rdata", host_rdata_o[1], 32'h0);
        nextCycle();

        $display("[TB] two hosts contend");
        applyStimulus(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 32'h0002_0004, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("t5_gnt_a", 32'(host_gnt_o), 32'h1);
        checkOutput("t5_dreq_a", 32'(device_req_o), 32'h1);
        nextCycle();
        host_req_i[0] = 1'b0;
        deviceResp(0, 1'b1, 32'hAAAA_0000, 1'b0);
        #1;
        checkOutput("t5_gnt_b", 32'(host_gnt_o), 32'h2);
        checkOutput("t5_dreq_b", 32'(device_req_o), 32'h2);
        checkOutput("t5_rvalid_a", 32'(host_rvalid_o), 32'h1);
        checkOutput("t5_rdata_a0", host_rdata_o[0], 32'hAAAA_0000);
        checkOutput("t5_rdata_a1", host_rdata_o[1], 32'h0);
        nextCycle();
        host_req_i[1] = 1'b0;
        clearDevices();
        deviceResp(1, 1'b1, 32'hBBBB_1111, 1'b0);
        #1;
        checkOutput("t5_rvalid_b", 32'(host_rvalid_o), 32'h2);
        checkOutput("t5_rdata_b1", host_rdata_o[1], 32'hBBBB_1111);
        checkOutput("t5_rdata_b0", host_rdata_o[0], 32'h0);
        nextCycle();
        clearDevices();

        $display("[TB] reset discards response");
        applyStimulus(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
        rst_i = 1'b1;
        #1;
        checkOutput("t6_gnt_rst", 32'(host_gnt_o), 32'h1);
        nextCycle();
        rst_i = 1'b0;
        host_req_i[0] = 1'b0;
        deviceResp(0, 1'b1, 32'h5555_5555, 1'b0);
        #1;
        checkOutput("t6_rst_rvalid", 32'(host_rvalid_o), 32'h0);
        checkOutput("t6_rst_rdata", host_rdata_o[0], 32'h0);
        nextCycle();
        clearDevices();

        $display("[TB] back-to-back reads");
        applyStimulus(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
        #1;
        checkOutput("t6_b2b_gnt0", 32'(host_gnt_o), 32'h1);
        nextCycle();
        host_addr_i[0] = 32'h0010_0004;
        deviceResp(0, 1'b1, 32'h1111_1111, 1'b0);
        #1;
        checkOutput("t6_b2b_gnt1", 32'(host_gnt_o), 32'h1);
        checkOutput("t6_b2b_daddr1", device_addr_o[0], 32'h0010_0004);
        checkOutput("t6_b2b_rvalid0", 32'(host_rvalid_o), 32'h1);
        checkOutput("t6_b2b_rdata0", host_rdata_o[0], 32'h1111_1111);
        nextCycle();
        host_req_i[0] = 1'b0;
        deviceResp(0, 1'b1, 32'h2222_2222, 1'b0);
        #1;
        checkOutput("t6_b2b_rvalid1", 32'(host_rvalid_o), 32'h1);
        checkOutput("t6_b2b_rdata1", host_rdata_o[0], 32'h2222_2222);
        nextCycle();
        clearDevices();
        #1;
        checkOutput("t6_b2b_idle", 32'(host_rvalid_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
